// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first,
// back-to-back for a programmable number of repetitions.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_shreg;
    logic [PAT_W-1:0] r_pat;
    logic [BIT_W-1:0] r_bitcnt;
    logic [CNT_W-1:0] r_rem;

    logic             w_lastBit;
    logic             w_lastRep;

    assign w_lastBit = (r_bitcnt == LAST_BIT);
    // rem is never zero while shifting, so "not one" means more repetitions remain
    assign w_lastRep = (r_rem == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_pat    <= '0;
            r_bitcnt <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (repeat_cnt != '0) begin
                            r_pat    <= pattern;
                            r_shreg  <= pattern;
                            r_rem    <= repeat_cnt;
                            r_bitcnt <= '0;
                            r_state  <= SHIFT;
                        end else begin
                            r_state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state  <= IDLE;
                        r_bitcnt <= '0;
                        r_rem    <= '0;
                    end else if (w_lastBit && !w_lastRep) begin
                        r_shreg  <= r_pat;
                        r_bitcnt <= '0;
                        r_rem    <= r_rem - CNT_W'(1);
                    end else if (w_lastBit) begin
                        r_shreg  <= {r_shreg[PAT_W-2:0], 1'b0};
                        r_bitcnt <= '0;
                        r_rem    <= '0;
                        r_state  <= DONE;
                    end else begin
                        r_shreg  <= {r_shreg[PAT_W-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt + BIT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs, decoded purely from registered state so reset clears them at once
    assign o_valid = (r_state == SHIFT);
    assign o       = r_shreg[PAT_W-1] & o_valid;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a queue of expected bits and done
// markers is filled at stimulus time and drained as the DUT emits them.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             o;
    logic             o_valid;
    logic             busy;
    logic             done;

    typedef struct {
        bit   isDone;
        logic bitVal;
    } expItem_t;

    expItem_t expQ[$];
    int       assertCount;
    int       failCount;
    int       detectorHits;
    logic [3:0] detectorHist;

    seq_pattern_tx #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .o          (o),
        .o_valid    (o_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0h, required %0h", tag, actual, expected);
        end
    endtask

    // Queues the expected stream, then pulses start for one cycle.
    // A non-negative bitsBeforeAbort means the bench will abort after that many bits.
    task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] cnt, input int bitsBeforeAbort);
        int       total;
        expItem_t it;
        total = (bitsBeforeAbort < 0) ? PAT_W * int'(cnt) : bitsBeforeAbort;
        for (int n = 0; n < total; n++) begin
            it.isDone = 1'b0;
            it.bitVal = pat[PAT_W - 1 - (n % PAT_W)];
            expQ.push_back(it);
        end
        if (bitsBeforeAbort < 0) begin
            it.isDone = 1'b1;
            it.bitVal = 1'b0;
            expQ.push_back(it);
        end
        @(negedge clk);
        pattern    = pat;
        repeat_cnt = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput("idleReached", busy, 0);
    endtask

    // Scoreboard drain: every valid bit and every done pulse must match the queue head
    always @(negedge clk) begin
        expItem_t it;
        if (!rst) begin
            if (o_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraBit", o_valid, 0);
                end else begin
                    it = expQ.pop_front();
                    checkOutput("bitOrder", o_valid, !it.isDone);
                    checkOutput("bitValue", o, it.bitVal);
                end
            end else begin
                checkOutput("oWhileInvalid", o, 0);
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraDone", done, 0);
                end else begin
                    it = expQ.pop_front();
                    checkOutput("doneOrder", done, it.isDone);
                end
            end
        end
    end

    // Downstream "1101" detector on the observed serial stream
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if ({detectorHist[2:0], o} == 4'b1101) detectorHits++;
            detectorHist = {detectorHist[2:0], o};
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount  = 0;
        failCount    = 0;
        detectorHits = 0;
        detectorHist = 4'b0000;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        pattern      = '0;
        repeat_cnt   = '0;

        @(negedge clk);
        checkOutput("rstO", o, 0);
        checkOutput("rstValid", o_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single pattern 1101 x1");
        applyStimulus(4'b1101, 4'd1, -1);
        for (int c = 1; c <= 6; c++) begin
            checkOutput("singleBusy", busy, (c <= 5));
            checkOutput("singleValid", o_valid, (c <= 4));
            checkOutput("singleDone", done, (c == 5));
            @(negedge clk);
        end

        $display("[TB] repeat pattern 1101 x3");
        detectorHits = 0;
        detectorHist = 4'b0000;
        applyStimulus(4'b1101, 4'd3, -1);
        for (int c = 1; c <= 13; c++) begin
            checkOutput("rptValid", o_valid, (c <= 12));
            checkOutput("rptDone", done, (c == 13));
            @(negedge clk);
        end
        checkOutput("detectorHits", detectorHits, 3);

        $display("[TB] zero repeat count");
        applyStimulus(4'b1111, 4'd0, -1);
        checkOutput("zeroBusy", busy, 1);
        checkOutput("zeroDone", done, 1);
        checkOutput("zeroValid", o_valid, 0);
        @(negedge clk);
        checkOutput("zeroBusyAfter", busy, 0);
        checkOutput("zeroDoneAfter", done, 0);

        $display("[TB] start ignored while busy");
        applyStimulus(4'b1001, 4'd2, -1);
        @(negedge clk);
        @(negedge clk);
        pattern    = 4'b0000;
        repeat_cnt = 4'd5;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        waitIdle(40);

        $display("[TB] abort during third bit");
        applyStimulus(4'b1011, 4'd2, 3);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortValid", o_valid, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(4'b0110, 4'd1, -1);
        waitIdle(20);

        $display("[TB] maximum repeat count");
        applyStimulus(4'b0110, 4'd15, -1);
        waitIdle(100);

        $display("[TB] async reset mid-shift");
        applyStimulus(4'b1101, 4'd2, -1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("asyncO", o, 0);
        checkOutput("asyncValid", o_valid, 0);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncDone", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstBusy", busy, 0);
        applyStimulus(4'b1101, 4'd1, -1);
        waitIdle(20);

        @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
